// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Purpose  : One player's score for the pong VGA pipeline. Keeps a saturating
//            BCD counter, decodes each digit to seven segments and renders the
//            digits at a movable pixel origin through a registered RGB output.
// Ports    : i_clk / i_reset      clock, synchronous active-high reset
//            i_clear              synchronous score clear (wins over i_point)
//            i_point              one-cycle pulse, add one point
//            i_frame              one-cycle pulse per frame start
//            i_font_x / i_font_y  digit-0 left edge / digit top edge
//            i_pixel_x/_y         current pixel position
//            i_visible_area       pixel is in the active area
//            o_score              BCD score, digit 0 (leftmost) in the MSBs
//            o_max                score saturated at all nines
//            o_r / o_g / o_b      pixel colour, one cycle after the pixel inputs
// Options  : define SCORE_FLASH_EN to blink the score for FLASH_FRAMES frames
//            after every accepted point.
// Revision : 1.0  initial release
// ============================================================================
module score_display #(
    parameter int         DIGITS       = 2,
    parameter int         SEG_LEN      = 20,
    parameter int         SEG_W        = 4,
    parameter int         GAP          = 8,
    parameter logic [2:0] COLOR        = 3'b100,
    parameter int         LEAD_BLANK   = 1,
    parameter int         FLASH_FRAMES = 60
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_point,
    input  logic                  i_frame,
    input  logic [9:0]            i_font_x,
    input  logic [9:0]            i_font_y,
    input  logic [9:0]            i_pixel_x,
    input  logic [9:0]            i_pixel_y,
    input  logic                  i_visible_area,
    output logic [4*DIGITS-1:0]   o_score,
    output logic                  o_max,
    output logic                  o_r,
    output logic                  o_g,
    output logic                  o_b
);

    localparam int c_pitch = SEG_LEN + SEG_W + GAP;

    // ------------------------------------------------------------------
    // Saturating BCD counter
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_score;
    logic [4*DIGITS-1:0] w_score_inc;
    logic                w_all_nine;
    logic                w_point_ok;

    always_comb begin
        w_all_nine = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_score[4*k +: 4] != 4'd9) begin
                w_all_nine = 1'b0;
            end
        end
    end

    assign w_point_ok = i_point && !i_clear && !w_all_nine;

    // Ripple the +1 from the least-significant slice (bits [3:0]) upward.
    always_comb begin
        logic carry;
        carry       = 1'b1;
        w_score_inc = r_score;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (r_score[4*k +: 4] == 4'd9) begin
                    w_score_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*k +: 4] = r_score[4*k +: 4] + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_score <= '0;
        end else if (w_point_ok) begin
            r_score <= w_score_inc;
        end
    end

    assign o_score = r_score;
    assign o_max   = w_all_nine;

    // ------------------------------------------------------------------
    // Flash gate
    // ------------------------------------------------------------------
    logic w_gate;

`ifdef SCORE_FLASH_EN
    logic [15:0] r_flash;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_flash <= '0;
        end else if (w_point_ok) begin
            r_flash <= 16'(FLASH_FRAMES);
        end else if (i_frame && (r_flash != 16'd0)) begin
            r_flash <= r_flash - 16'd1;
        end
    end

    // Bit 3 toggles every 8 frames, which gives the on/off blink.
    assign w_gate = (r_flash == 16'd0) || !r_flash[3];
`else
    logic w_unused;
    assign w_unused = i_frame | (FLASH_FRAMES < 0);
    assign w_gate   = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Segment decode and rendering
    // ------------------------------------------------------------------
    // Bit order: 0 top, 1 upper-left, 2 upper-right, 3 middle,
    //            4 lower-left, 5 lower-right, 6 bottom.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1110111;
            4'd1:    seg_decode = 7'b0100100;
            4'd2:    seg_decode = 7'b1011101;
            4'd3:    seg_decode = 7'b1101101;
            4'd4:    seg_decode = 7'b0101110;
            4'd5:    seg_decode = 7'b1101011;
            4'd6:    seg_decode = 7'b1111011;
            4'd7:    seg_decode = 7'b0100101;
            4'd8:    seg_decode = 7'b1111111;
            4'd9:    seg_decode = 7'b1101111;
            default: seg_decode = 7'b0000000;
        endcase
    endfunction

    // 13-bit arithmetic keeps origins past column 1023 from wrapping onto
    // low coordinates.
    function automatic logic in_rect(
        input logic [12:0] px,
        input logic [12:0] py,
        input logic [12:0] ox,
        input logic [12:0] oy,
        input int          x0,
        input int          x1,
        input int          y0,
        input int          y1
    );
        in_rect = (px >= ox + 13'(x0)) && (px < ox + 13'(x1)) &&
                  (py >= oy + 13'(y0)) && (py < oy + 13'(y1));
    endfunction

    logic w_hit;

    always_comb begin
        logic        lead;
        logic        blank;
        logic [3:0]  digit;
        logic [6:0]  segs;
        logic [12:0] px;
        logic [12:0] py;
        logic [12:0] ox;
        logic [12:0] oy;
        w_hit = 1'b0;
        lead  = 1'b1;
        px    = {3'b000, i_pixel_x};
        py    = {3'b000, i_pixel_y};
        oy    = {3'b000, i_font_y};
        for (int k = 0; k < DIGITS; k++) begin
            digit = r_score[4*(DIGITS-1-k) +: 4];
            // Blank only while every more-significant digit is also zero;
            // the rightmost digit is always drawn.
            blank = (LEAD_BLANK != 0) && lead && (digit == 4'd0) && (k != DIGITS-1);
            if (digit != 4'd0) begin
                lead = 1'b0;
            end
            segs = seg_decode(digit);
            ox   = {3'b000, i_font_x} + 13'(k * c_pitch);
            if (!blank) begin
                w_hit = w_hit
                    | (segs[0] & in_rect(px, py, ox, oy, SEG_W,   SEG_LEN,       0,               SEG_W))
                    | (segs[1] & in_rect(px, py, ox, oy, 0,       SEG_W,         SEG_W,           SEG_LEN))
                    | (segs[2] & in_rect(px, py, ox, oy, SEG_LEN, SEG_LEN+SEG_W, SEG_W,           SEG_LEN))
                    | (segs[3] & in_rect(px, py, ox, oy, SEG_W,   SEG_LEN,       SEG_LEN,         SEG_LEN+SEG_W))
                    | (segs[4] & in_rect(px, py, ox, oy, 0,       SEG_W,         SEG_LEN+SEG_W,   2*SEG_LEN))
                    | (segs[5] & in_rect(px, py, ox, oy, SEG_LEN, SEG_LEN+SEG_W, SEG_LEN+SEG_W,   2*SEG_LEN))
                    | (segs[6] & in_rect(px, py, ox, oy, SEG_W,   SEG_LEN,       2*SEG_LEN,       2*SEG_LEN+SEG_W));
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered RGB output
    // ------------------------------------------------------------------
    logic [2:0] r_rgb;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rgb <= 3'b000;
        end else if (i_visible_area && w_hit && w_gate) begin
            r_rgb <= COLOR;
        end else begin
            r_rgb <= 3'b000;
        end
    end

    assign o_r = r_rgb[2];
    assign o_g = r_rgb[1];
    assign o_b = r_rgb[0];

endmodule
`default_nettype wire
